// File: rtl/gate_tt_sweeper.sv
// rtl/gate_tt_sweeper.sv - sequential truth-table sweeper for 2-input gates
// Drives a/b through 00..11, samples gate_o after a settle window, reports mismatches.
module gate_tt_sweeper #(
  parameter int SETTLE_CYC = 2,
  parameter int CNT_W      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] exp_tt,
  input  logic       gate_o,
  output logic       a,
  output logic       b,
  output logic [1:0] vec_idx,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_mask
);

  typedef enum logic {IDLE, SETTLE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       exp_q, exp_d;
  logic [3:0]       err_d, err_upd;
  logic [1:0]       vec_d;
  logic             a_d, b_d, busy_d, done_d, pass_d;
  logic             sample_edge;

  assign sample_edge = (cnt_q == CNT_W'(SETTLE_CYC - 1));

  // Result mask including the vector being sampled this edge.
  always_comb begin
    err_upd          = err_mask;
    err_upd[vec_idx] = gate_o ^ exp_q[vec_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SETTLE;
      SETTLE:  if (sample_edge && vec_idx == 2'd3) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    exp_d  = exp_q;
    err_d  = err_mask;
    vec_d  = vec_idx;
    a_d    = a;
    b_d    = b;
    busy_d = busy;
    pass_d = pass;
    done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          exp_d      = exp_tt;
          vec_d      = 2'd0;
          {a_d, b_d} = 2'b00;
          err_d      = 4'd0;
          pass_d     = 1'b0;
          busy_d     = 1'b1;
          cnt_d      = '0;
        end
      end
      SETTLE: begin
        if (sample_edge) begin
          cnt_d = '0;
          err_d = err_upd;
          if (vec_idx != 2'd3) begin
            vec_d      = vec_idx + 2'd1;
            {a_d, b_d} = vec_idx + 2'd1;
          end else begin
            done_d     = 1'b1;
            pass_d     = (err_upd == 4'd0);
            busy_d     = 1'b0;
            vec_d      = 2'd0;
            {a_d, b_d} = 2'b00;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      exp_q    <= 4'd0;
      err_mask <= 4'd0;
      vec_idx  <= 2'd0;
      a        <= 1'b0;
      b        <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      exp_q    <= exp_d;
      err_mask <= err_d;
      vec_idx  <= vec_d;
      a        <= a_d;
      b        <= b_d;
      busy     <= busy_d;
      done     <= done_d;
      pass     <= pass_d;
    end
  end

endmodule

// File: tb/tb_gate_tt_sweeper.sv
// tb/tb_gate_tt_sweeper.sv - self-checking bench for gate_tt_sweeper
// Scoreboard of expected sweep results, popped on each done pulse.
module tb_gate_tt_sweeper;

  typedef struct {
    logic [1:0] gsel;
    logic [3:0] exp_tt;
    logic       exp_pass;
    logic [3:0] exp_err;
  } vec_t;

  typedef struct {
    logic       pass;
    logic [3:0] err;
    int         cyc;
  } sb_t;

  logic clk = 1'b0;
  logic rst_n;
  logic start, start3;
  logic [3:0] exp_tt, exp3;
  logic [1:0] gsel;
  logic gate_o, gate3;
  logic a, b, busy, done, pass;
  logic a3, b3, busy3, done3, pass3;
  logic [1:0] vec_idx, vec_idx3;
  logic [3:0] err_mask, err3;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int k = 0, k3 = 0;
  int done3_cnt = 0, done3_cyc = 0;
  sb_t sb[$];
  vec_t vecs[6];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 0: NAND, 1: tied 0, 2: tied 1, 3: XOR
  always_comb begin
    case (gsel)
      2'd0:    gate_o = ~(a & b);
      2'd1:    gate_o = 1'b0;
      2'd2:    gate_o = 1'b1;
      default: gate_o = a ^ b;
    endcase
  end
  assign gate3 = ~(a3 & b3);

  gate_tt_sweeper #(.SETTLE_CYC(2), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .exp_tt(exp_tt), .gate_o(gate_o),
    .a(a), .b(b), .vec_idx(vec_idx), .busy(busy), .done(done), .pass(pass),
    .err_mask(err_mask)
  );

  gate_tt_sweeper #(.SETTLE_CYC(3), .CNT_W(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .exp_tt(exp3), .gate_o(gate3),
    .a(a3), .b(b3), .vec_idx(vec_idx3), .busy(busy3), .done(done3), .pass(pass3),
    .err_mask(err3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    sb_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        k = 0;
        k3 = 0;
      end else begin
        if (busy) begin
          check("ab_order", {30'd0, a, b}, k / 2);
          check("vec_idx", {30'd0, vec_idx}, k / 2);
          k++;
        end
        if (done) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done at cyc %0d expected none", cyc);
          end else begin
            e = sb.pop_front();
            check("done_cyc", cyc, e.cyc);
            check("pass", {31'd0, pass}, {31'd0, e.pass});
            check("err_mask", {28'd0, err_mask}, {28'd0, e.err});
            check("busy_len", k, 8);
          end
          k = 0;
        end
        if (busy3) begin
          check("ab_order3", {30'd0, a3, b3}, k3 / 3);
          k3++;
        end
        if (done3) begin
          check("busy_len3", k3, 12);
          done3_cnt++;
          done3_cyc = cyc;
          k3 = 0;
        end
      end
    end
  endtask

  task automatic wait_sb_empty(input int limit);
    int n = 0;
    while (sb.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL sb_timeout: got %0d pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic push_exp(input logic p, input logic [3:0] e, input int at);
    sb_t s;
    s.pass = p;
    s.err  = e;
    s.cyc  = at;
    sb.push_back(s);
  endtask

  task automatic sweep(input logic [1:0] gs, input logic [3:0] tt, input logic p, input logic [3:0] e);
    @(negedge clk);
    gsel   = gs;
    exp_tt = tt;
    start  = 1'b1;
    push_exp(p, e, cyc + 9);
    @(negedge clk);
    start = 1'b0;
    wait_sb_empty(40);
  endtask

  task automatic run_tests();
    int n0;
    int n;
    vecs[0] = '{2'd0, 4'b0111, 1'b1, 4'b0000};
    vecs[1] = '{2'd0, 4'b1000, 1'b0, 4'b1111};
    vecs[2] = '{2'd1, 4'b0111, 1'b0, 4'b0111};
    vecs[3] = '{2'd2, 4'b0111, 1'b0, 4'b1000};
    vecs[4] = '{2'd3, 4'b0110, 1'b1, 4'b0000};
    vecs[5] = '{2'd0, 4'b0110, 1'b0, 4'b0001};

    repeat (2) @(negedge clk);
    check("reset_state", {23'd0, a, b, vec_idx, busy, done, pass, err_mask}, 0);
    check("reset_state3", {23'd0, a3, b3, vec_idx3, busy3, done3, pass3, err3}, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      sweep(vecs[i].gsel, vecs[i].exp_tt, vecs[i].exp_pass, vecs[i].exp_err);
      repeat (3) @(negedge clk);
      check("held_pass", {31'd0, pass}, {31'd0, vecs[i].exp_pass});
      check("held_err", {28'd0, err_mask}, {28'd0, vecs[i].exp_err});
      check("done_low", {31'd0, done}, 0);
    end

    // Second start while busy must be ignored on the S=3 instance.
    @(negedge clk);
    start3 = 1'b1;
    n0 = cyc;
    @(negedge clk);
    start3 = 1'b0;
    while (cyc < n0 + 5) @(negedge clk);
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    repeat (25) @(negedge clk);
    check("done3_count", done3_cnt, 1);
    check("done3_cyc", done3_cyc, n0 + 13);
    check("pass3", {31'd0, pass3}, 1);
    check("err3", {28'd0, err3}, 0);

    // Reset mid-sweep aborts without a done pulse.
    @(negedge clk);
    gsel = 2'd0;
    exp_tt = 4'b0111;
    start = 1'b1;
    push_exp(1'b1, 4'b0000, cyc + 9);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (vec_idx != 2'd2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("reach_vec2", {30'd0, vec_idx}, 2);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("reset_abort", {23'd0, a, b, vec_idx, busy, done, pass, err_mask}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    sweep(2'd0, 4'b0111, 1'b1, 4'b0000);

    // start held high: back-to-back sweeps; exp_tt change lands on the next one.
    @(negedge clk);
    gsel = 2'd0;
    exp_tt = 4'b0111;
    start = 1'b1;
    push_exp(1'b1, 4'b0000, cyc + 9);
    push_exp(1'b0, 4'b0111, cyc + 18);
    repeat (3) @(negedge clk);
    exp_tt = 4'b0000;
    n = 0;
    while (sb.size() > 1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("restart_busy", {31'd0, busy}, 1);
    check("restart_clear", {27'd0, pass, err_mask}, 0);
    start = 1'b0;
    wait_sb_empty(30);
    repeat (12) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    start3 = 1'b0;
    exp_tt = 4'b0111;
    exp3 = 4'b0111;
    gsel = 2'd0;
    fork
      monitor();
      run_tests();
    join_any
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
